// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch / prefetch queue block.
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DATA_W_DEF   = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Request side: idle, or a presented request waiting for mem_req_ready.
  typedef enum logic {
    REQ_IDLE = 1'b0,
    REQ_HOLD = 1'b1
  } req_state_t;

  // Queue entry layout at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] data;
    logic                  filled;
  } fetch_entry_t;

  // Pointer width: one extra MSB separates full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Memory request/response and core-side instruction handshake bundle.
// master = fetch unit, slave = the memory/core side it talks to.
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ins_valid;
  logic              ins_ready;
  logic [ADDR_W-1:0] ins_pc;
  logic [DATA_W-1:0] ins_data;

  modport master (
    output mem_req_valid, mem_req_addr, ins_valid, ins_pc, ins_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, ins_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, ins_valid, ins_pc, ins_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, ins_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue_ring.sv
// fetch_entry_ring: in-order entry storage for the prefetch queue.
// tail allocates on request issue, fptr fills in response order,
// head pops to the core; flush empties everything in one cycle.
module fetch_entry_ring
  import fetch_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int PW     = ptr_w(DEPTH)
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              flush,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              pop,
  output logic              head_filled,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data,
  output logic [PW-1:0]     count
);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic              filled;
  } entry_t;

  entry_t          ent [DEPTH];
  logic [PW-1:0]   head, tail, fptr;
  logic [PW-2:0]   head_idx, tail_idx, fill_idx;
  logic            fill_ok;

  assign head_idx = head[PW-2:0];
  assign tail_idx = tail[PW-2:0];
  assign fill_idx = fptr[PW-2:0];
  assign count    = tail - head;
  // A fill can only target an allocated, not yet filled slot.
  assign fill_ok  = fill && (fptr != tail);

  assign head_filled = ent[head_idx].filled && (count != '0);
  assign head_pc     = ent[head_idx].pc;
  assign head_data   = ent[head_idx].data;

  // Pointer and entry update; flush beats alloc/fill/pop.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      head <= '0;
      tail <= '0;
      fptr <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      fptr <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        ent[tail_idx].pc     <= alloc_pc;
        ent[tail_idx].filled <= 1'b0;
        tail                 <= tail + PW'(1);
      end
      if (fill_ok) begin
        ent[fill_idx].data   <= fill_data;
        ent[fill_idx].filled <= 1'b1;
        fptr                 <= fptr + PW'(1);
      end
      if (pop) head <= head + PW'(1);
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction fetch with an in-order
// prefetch queue feeding decode. A redirect flushes the queue and marks
// every in-flight response as stale so it is dropped on return.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_flushes.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  enable,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  fetch_prefetch_queue_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [15:0]           stat_flushes
`endif
);
  localparam int PW = ptr_w(DEPTH);

  req_state_t        req_st, req_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     outstanding, drop_cnt, count;
  logic              run_q;
  logic              can_issue, req_valid, req_hs;
  logic              fill, pop, head_filled;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_data;

  // New requests need room both in the queue and in the response budget.
  // run_q keeps the request side quiet while reset is held.
  assign can_issue = run_q && enable && (count < PW'(DEPTH)) && (outstanding < PW'(DEPTH));
  assign req_hs    = req_valid && bus.mem_req_ready;
  assign fill      = bus.mem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.ins_valid     = head_filled && !redirect_valid;
  assign bus.ins_pc        = head_pc;
  assign bus.ins_data      = head_data;
  assign pop               = bus.ins_valid && bus.ins_ready;

  // Request FSM state register.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) req_st <= REQ_IDLE;
    else         req_st <= req_nx;
  end

  // Request FSM: once presented, a request stays up until accepted;
  // only a redirect withdraws it.
  always_comb begin
    req_nx    = req_st;
    req_valid = 1'b0;
    if (redirect_valid) begin
      req_nx = REQ_IDLE;
    end else begin
      case (req_st)
        REQ_IDLE: if (can_issue) begin
          req_valid = 1'b1;
          if (!bus.mem_req_ready) req_nx = REQ_HOLD;
        end
        REQ_HOLD: begin
          req_valid = 1'b1;
          if (bus.mem_req_ready) req_nx = REQ_IDLE;
        end
        default: req_nx = REQ_IDLE;
      endcase
    end
  end

  // Fetch PC: redirect target (word aligned) or advance on each accepted request.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)             fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc & ~ADDR_W'(3);
    else if (req_hs)         fetch_pc <= fetch_pc + ADDR_W'(4);
  end

  // In-flight and stale-response accounting. On redirect everything still
  // in flight after this cycle's response becomes stale.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      run_q       <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      outstanding <= outstanding + PW'(req_hs) - PW'(bus.mem_rsp_valid);
      if (redirect_valid)
        drop_cnt <= outstanding - PW'(bus.mem_rsp_valid);
      else if (bus.mem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - PW'(1);
    end
  end

  fetch_entry_ring #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .gclk        (gclk),
    .grst_n      (grst_n),
    .flush       (redirect_valid),
    .alloc       (req_hs),
    .alloc_pc    (fetch_pc),
    .fill        (fill),
    .fill_data   (bus.mem_rsp_data),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_data   (head_data),
    .count       (count)
  );

`ifdef FETCH_STATS_EN
  // Saturating counters of delivered instructions and redirects.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      stat_fetched <= '0;
      stat_flushes <= '0;
    end else begin
      if (pop && (stat_fetched != '1))            stat_fetched <= stat_fetched + 32'd1;
      if (redirect_valid && (stat_flushes != '1)) stat_flushes <= stat_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with programmable
// latency, request-address model and a (pc,data) scoreboard.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic          enable = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetched;
  logic [15:0]   stat_flushes;
`endif

  fetch_prefetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fetch_prefetch_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .gclk(gclk), .grst_n(grst_n), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .bus(bus)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
  );

  always #5 gclk = ~gclk;

  int            nchk = 0, nfail = 0, cyc = 0, lat = 1;
  logic [AW-1:0] exp_addr = RPC;
  logic [AW-1:0] mem_addr_q[$];
  int            mem_due_q[$];
  logic [AW-1:0] exp_pc_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] req_log[$], ins_log[$];
  int            req_cyc[$], ins_cyc[$];
  logic          last_ins_valid = 1'b0;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic clear_logs();
    req_log.delete(); ins_log.delete(); req_cyc.delete(); ins_cyc.delete();
  endtask

  // One clock: present memory response, observe handshakes at negedge,
  // return at posedge+1 ready for the next cycle's inputs.
  task automatic tick();
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = memfn(mem_addr_q[0]);
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
    end
    @(negedge gclk);
    last_ins_valid = bus.ins_valid;
    if (redirect_valid) begin
      nchk++;
      if (bus.mem_req_valid !== 1'b0 || bus.ins_valid !== 1'b0) begin
        nfail++;
        $display("FAIL redirect_quiet: req_valid=%b ins_valid=%b, want 0 0", bus.mem_req_valid, bus.ins_valid);
      end
      exp_pc_q.delete(); exp_data_q.delete();
      exp_addr = redirect_pc & ~32'h3;
    end else begin
      if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
        nchk++;
        if (bus.mem_req_addr !== exp_addr) begin
          nfail++;
          $display("FAIL req_addr: got %h want %h", bus.mem_req_addr, exp_addr);
        end
        req_log.push_back(bus.mem_req_addr); req_cyc.push_back(cyc);
        mem_addr_q.push_back(bus.mem_req_addr); mem_due_q.push_back(cyc + lat);
        exp_pc_q.push_back(exp_addr); exp_data_q.push_back(memfn(exp_addr));
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.ins_valid === 1'b1 && bus.ins_ready) begin
        ins_log.push_back(bus.ins_pc); ins_cyc.push_back(cyc);
        nchk++;
        if (exp_pc_q.size() == 0) begin
          nfail++;
          $display("FAIL ins_unexpected: got pc=%h data=%h, want no instruction", bus.ins_pc, bus.ins_data);
        end else begin
          if (bus.ins_pc !== exp_pc_q[0] || bus.ins_data !== exp_data_q[0]) begin
            nfail++;
            $display("FAIL ins_pair: got pc=%h data=%h want pc=%h data=%h",
                     bus.ins_pc, bus.ins_data, exp_pc_q[0], exp_data_q[0]);
          end
          void'(exp_pc_q.pop_front()); void'(exp_data_q.pop_front());
        end
      end
    end
    if (bus.mem_rsp_valid) begin
      void'(mem_addr_q.pop_front()); void'(mem_due_q.pop_front());
    end
    @(posedge gclk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    grst_n = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.mem_req_ready = 1'b0; bus.ins_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    mem_addr_q.delete(); mem_due_q.delete(); exp_pc_q.delete(); exp_data_q.delete();
    exp_addr = RPC;
    repeat (2) @(posedge gclk);
    #1 grst_n = 1'b1;
  endtask

  task automatic test_reset();
    grst_n = 1'b0; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    @(posedge gclk); #1;
    nchk++; if (bus.mem_req_valid !== 1'b0) begin nfail++; $display("FAIL rst_req_valid: got %b want 0", bus.mem_req_valid); end
    nchk++; if (bus.mem_req_addr !== RPC) begin nfail++; $display("FAIL rst_req_addr: got %h want %h", bus.mem_req_addr, RPC); end
    nchk++; if (bus.ins_valid !== 1'b0) begin nfail++; $display("FAIL rst_ins_valid: got %b want 0", bus.ins_valid); end
    nchk++; if (bus.ins_pc !== '0) begin nfail++; $display("FAIL rst_ins_pc: got %h want 0", bus.ins_pc); end
    nchk++; if (bus.ins_data !== '0) begin nfail++; $display("FAIL rst_ins_data: got %h want 0", bus.ins_data); end
  endtask

  task automatic test_stream();
    do_reset(); lat = 1; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    clear_logs();
    repeat (12) tick();
    nchk++;
    if (req_log.size() < 4 || ins_log.size() < 4) begin
      nfail++; $display("FAIL t1_progress: reqs=%0d ins=%0d want >=4 each", req_log.size(), ins_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchk++; if (req_log[i] !== 32'(i * 4)) begin nfail++; $display("FAIL t1_addr%0d: got %h want %h", i, req_log[i], 32'(i * 4)); end
        nchk++; if (ins_log[i] !== 32'(i * 4)) begin nfail++; $display("FAIL t1_pc%0d: got %h want %h", i, ins_log[i], 32'(i * 4)); end
      end
      nchk++; if (ins_cyc[0] - req_cyc[0] != 2) begin nfail++; $display("FAIL t1_latency: got %0d want 2", ins_cyc[0] - req_cyc[0]); end
      nchk++; if (ins_cyc[3] - ins_cyc[0] != 3) begin nfail++; $display("FAIL t1_b2b: got %0d want 3", ins_cyc[3] - ins_cyc[0]); end
    end
  endtask

  task automatic test_full_stall();
    do_reset(); lat = 1; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b0;
    clear_logs();
    repeat (8) tick();
    nchk++; if (req_log.size() != 4) begin nfail++; $display("FAIL t2_req_count: got %0d want 4", req_log.size()); end
    nchk++; if (bus.mem_req_valid !== 1'b0) begin nfail++; $display("FAIL t2_full_valid: got %b want 0", bus.mem_req_valid); end
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if (bus.ins_valid !== 1'b1 || bus.ins_pc !== 32'h0 || bus.ins_data !== memfn(32'h0)) begin
        nfail++; $display("FAIL t2_hold: got v=%b pc=%h data=%h want 1 0 %h", bus.ins_valid, bus.ins_pc, bus.ins_data, memfn(32'h0));
      end
      tick();
    end
    bus.ins_ready = 1'b1; tick(); bus.ins_ready = 1'b0;
    repeat (4) tick();
    nchk++;
    if (req_log.size() != 5) begin
      nfail++; $display("FAIL t2_refill_count: got %0d want 5", req_log.size());
    end else if (req_log[4] !== 32'h10) begin
      nfail++; $display("FAIL t2_refill_addr: got %h want 00000010", req_log[4]);
    end
    nchk++; if (bus.ins_pc !== 32'h4) begin nfail++; $display("FAIL t2_next_head: got %h want 00000004", bus.ins_pc); end
  endtask

  task automatic test_redirect_inflight();
    do_reset(); lat = 5; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    tick(); clear_logs();
    repeat (3) tick();
    nchk++; if (req_log.size() != 3) begin nfail++; $display("FAIL t3_inflight: got %0d want 3", req_log.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h103; tick(); redirect_valid = 1'b0;
    for (int k = 0; k < 40 && ins_log.size() == 0; k++) tick();
    nchk++;
    if (ins_log.size() == 0) begin
      nfail++; $display("FAIL t3_timeout: got no instruction, want pc 00000100");
    end else if (ins_log[0] !== 32'h100) begin
      nfail++; $display("FAIL t3_first_pc: got %h want 00000100", ins_log[0]);
    end
    nchk++;
    if (req_log.size() < 4 || req_log[3] !== 32'h100) begin
      nfail++; $display("FAIL t3_req_addr: got %0d reqs, want 4th addr 00000100", req_log.size());
    end
  endtask

  task automatic test_redirect_collide();
    do_reset(); lat = 2; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    repeat (10) tick();
    nchk++; if (last_ins_valid !== 1'b1) begin nfail++; $display("FAIL t4_pre_valid: got %b want 1", last_ins_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h200; tick(); redirect_valid = 1'b0;
    nchk++; if (bus.ins_valid !== 1'b0) begin nfail++; $display("FAIL t4_empty: got %b want 0", bus.ins_valid); end
    clear_logs();
    for (int k = 0; k < 30 && ins_log.size() < 2; k++) tick();
    nchk++;
    if (ins_log.size() < 2) begin
      nfail++; $display("FAIL t4_timeout: got %0d instructions want 2", ins_log.size());
    end else if (ins_log[0] !== 32'h200 || ins_log[1] !== 32'h204) begin
      nfail++; $display("FAIL t4_pcs: got %h %h want 00000200 00000204", ins_log[0], ins_log[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1; enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; tick(); redirect_valid = 1'b0;
    clear_logs();
    repeat (8) tick();
    nchk++;
    if (req_log.size() < 3) begin
      nfail++; $display("FAIL t5_reqs: got %0d want >=3", req_log.size());
    end else if (req_log[0] !== 32'hFFFF_FFF8 || req_log[1] !== 32'hFFFF_FFFC || req_log[2] !== 32'h0) begin
      nfail++; $display("FAIL t5_addrs: got %h %h %h want fffffff8 fffffffc 00000000", req_log[0], req_log[1], req_log[2]);
    end
    nchk++;
    if (ins_log.size() < 3 || ins_log[2] !== 32'h0) begin
      nfail++; $display("FAIL t5_ins_wrap: got %0d instructions, want third pc 00000000", ins_log.size());
    end
  endtask

  task automatic test_hold_and_reset();
    do_reset(); lat = 1; enable = 1'b1; bus.mem_req_ready = 1'b0; bus.ins_ready = 1'b1;
    clear_logs();
    tick(); tick();
    nchk++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin nfail++; $display("FAIL t6_pending: got v=%b a=%h want 1 0", bus.mem_req_valid, bus.mem_req_addr); end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nchk++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin
        nfail++; $display("FAIL t6_hold: got v=%b a=%h want 1 00000000", bus.mem_req_valid, bus.mem_req_addr);
      end
    end
    bus.mem_req_ready = 1'b1; tick();
    repeat (3) tick();
    nchk++; if (req_log.size() != 1) begin nfail++; $display("FAIL t6_one_req: got %0d want 1", req_log.size()); end
    nchk++; if (bus.mem_req_valid !== 1'b0) begin nfail++; $display("FAIL t6_idle: got %b want 0", bus.mem_req_valid); end
    enable = 1'b1;
    repeat (6) tick();
    nchk++; if (bus.ins_valid !== 1'b1) begin nfail++; $display("FAIL t6_burst: got %b want 1", bus.ins_valid); end
    grst_n = 1'b0; #1;
    nchk++; if (bus.mem_req_valid !== 1'b0) begin nfail++; $display("FAIL t6_rst_valid: got %b want 0", bus.mem_req_valid); end
    nchk++; if (bus.mem_req_addr !== RPC) begin nfail++; $display("FAIL t6_rst_addr: got %h want %h", bus.mem_req_addr, RPC); end
    nchk++; if (bus.ins_valid !== 1'b0 || bus.ins_pc !== '0 || bus.ins_data !== '0) begin
      nfail++; $display("FAIL t6_rst_ins: got v=%b pc=%h d=%h want 0 0 0", bus.ins_valid, bus.ins_pc, bus.ins_data);
    end
    do_reset(); enable = 1'b1; bus.mem_req_ready = 1'b1; bus.ins_ready = 1'b1;
    clear_logs();
    repeat (6) tick();
    nchk++;
    if (req_log.size() == 0 || req_log[0] !== RPC) begin
      nfail++; $display("FAIL t6_restart: got %0d reqs, want first addr %h", req_log.size(), RPC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
